// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM arbiter: FSM states, grant sides, default widths.
package sram_arb_pkg;

   localparam int unsigned ARB_ADDR_W = 20;
   localparam int unsigned ARB_DATA_W = 16;
   localparam int unsigned ARB_CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_e;

   // Round-robin pick; on a tie the side that did not win last time goes next.
   function automatic grant_e rr_pick(input logic wr, input logic rd, input grant_e last);
      grant_e g;
      if (wr && rd) g = (last == GNT_RD) ? GNT_WR : GNT_RD;
      else if (wr)  g = GNT_WR;
      else          g = GNT_RD;
      return g;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle of the SRAM arbiter (recorder writes, DSP reads).
interface sram_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W
);

   logic              i_wr_req;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_ack;
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              o_rd_ack;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_busy;

   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
      output o_wr_ack, o_rd_ack, o_rd_data, o_busy
   );

   modport master (
      output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
      input  o_wr_ack, o_rd_ack, o_rd_data, o_busy
   );

endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between a write requester and a read requester.
// All SRAM strobes, address and DQ enable come straight from registers.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 1,
   parameter int unsigned ADDR_W        = ARB_ADDR_W,
   parameter int unsigned DATA_W        = ARB_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   sram_arbiter_if.slave     req_if,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(ACCESS_CYCLES - 1);

   generate
      if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 7) begin : g_bad_access_cycles
         $error("sram_arbiter: ACCESS_CYCLES must be in 1..7");
      end
   endgenerate

   state_e                r_state;
   grant_e                r_last;
   logic [ARB_CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rd_data;
   logic                  r_dq_oe;
   logic                  r_we_n;
   logic                  r_oe_n;
   logic                  r_ce_n;
   logic                  r_wr_ack;
   logic                  r_rd_ack;
   logic                  r_busy;

   logic                  w_any_req;
   grant_e                w_pick;

   assign w_any_req = req_if.i_wr_req | req_if.i_rd_req;
   assign w_pick    = rr_pick(req_if.i_wr_req, req_if.i_rd_req, r_last);

   // Arbitration, access timing and strobe generation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_last    <= GNT_RD;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd_data <= '0;
         r_dq_oe   <= 1'b0;
         r_we_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_ce_n    <= 1'b1;
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_wr_ack <= 1'b0;
         r_rd_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_last <= w_pick;
                  r_cnt  <= CNT_LOAD;
                  r_ce_n <= 1'b0;
                  r_busy <= 1'b1;
                  if (w_pick == GNT_WR) begin
                     r_state <= WRITE;
                     r_addr  <= req_if.i_wr_addr;
                     r_wdata <= req_if.i_wr_data;
                     r_we_n  <= 1'b0;
                     r_dq_oe <= 1'b1;
                  end else begin
                     r_state <= READ;
                     r_addr  <= req_if.i_rd_addr;
                     r_oe_n  <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (r_cnt == '0) begin
                  r_state  <= DONE;
                  r_we_n   <= 1'b1;
                  r_ce_n   <= 1'b1;
                  r_dq_oe  <= 1'b0;
                  r_wr_ack <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - ARB_CNT_W'(1);
               end
            end
            READ: begin
               // Data is sampled on the edge that ends the last OE_N-low cycle.
               if (r_cnt == '0) begin
                  r_state   <= DONE;
                  r_oe_n    <= 1'b1;
                  r_ce_n    <= 1'b1;
                  r_rd_data <= io_SRAM_DQ;
                  r_rd_ack  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - ARB_CNT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign io_SRAM_DQ       = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
   assign o_SRAM_ADDR      = r_addr;
   assign o_SRAM_WE_N      = r_we_n;
   assign o_SRAM_OE_N      = r_oe_n;
   assign o_SRAM_CE_N      = r_ce_n;
   assign o_SRAM_LB_N      = 1'b0;
   assign o_SRAM_UB_N      = 1'b0;

   assign req_if.o_wr_ack  = r_wr_ack;
   assign req_if.o_rd_ack  = r_rd_ack;
   assign req_if.o_rd_data = r_rd_data;
   assign req_if.o_busy    = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed cases plus random traffic against a reference memory.
module tb_sram_arbiter;

   localparam int unsigned AW    = 20;
   localparam int unsigned DW    = 16;
   localparam int unsigned A1    = 1;
   localparam int unsigned A3    = 3;
   localparam int unsigned MEM_N = 4096;
   localparam int unsigned BOUND = 2 * (A1 + 2);
   localparam int unsigned N_RND = 10000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   logic [AW-1:0] s1_addr, s3_addr;
   wire  [DW-1:0] s1_dq, s3_dq;
   logic          s1_we_n, s1_ce_n, s1_oe_n, s1_lb_n, s1_ub_n;
   logic          s3_we_n, s3_ce_n, s3_oe_n, s3_lb_n, s3_ub_n;

   sram_arbiter #(.ACCESS_CYCLES(A1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .req_if(bus1),
      .o_SRAM_ADDR(s1_addr), .io_SRAM_DQ(s1_dq),
      .o_SRAM_WE_N(s1_we_n), .o_SRAM_CE_N(s1_ce_n), .o_SRAM_OE_N(s1_oe_n),
      .o_SRAM_LB_N(s1_lb_n), .o_SRAM_UB_N(s1_ub_n)
   );

   sram_arbiter #(.ACCESS_CYCLES(A3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .req_if(bus3),
      .o_SRAM_ADDR(s3_addr), .io_SRAM_DQ(s3_dq),
      .o_SRAM_WE_N(s3_we_n), .o_SRAM_CE_N(s3_ce_n), .o_SRAM_OE_N(s3_oe_n),
      .o_SRAM_LB_N(s3_lb_n), .o_SRAM_UB_N(s3_ub_n)
   );

   // SRAM model: drives stored data while read-enabled, zeros otherwise, releases the bus during writes.
   logic [DW-1:0] mem1    [MEM_N];
   logic [DW-1:0] ref_mem [MEM_N];
   logic [DW-1:0] s1_drv, s3_drv;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return 16'(a[15:0] * 16'h1357 + 16'h2468);
   endfunction

   always_comb s1_drv = (!s1_oe_n && !s1_ce_n) ? mem1[s1_addr[11:0]] : '0;
   always_comb s3_drv = (!s3_oe_n && !s3_ce_n) ? pat(s3_addr) : '0;
   assign s1_dq = s1_we_n ? s1_drv : 16'hzzzz;
   assign s3_dq = s3_we_n ? s3_drv : 16'hzzzz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock; SRAM write strobe captured with this cycle's bus values before the edge.
   task automatic tick;
      if (!s1_ce_n && !s1_we_n) mem1[s1_addr[11:0]] = s1_dq;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus1.i_wr_req = 1'b1; bus1.i_wr_addr = a; bus1.i_wr_data = d;
      tick;
      chk("wr_we_low",  32'(s1_we_n), 32'd0);
      chk("wr_oe_high", 32'(s1_oe_n), 32'd1);
      chk("wr_ce_low",  32'(s1_ce_n), 32'd0);
      chk("wr_addr",    32'(s1_addr), 32'(a));
      chk("wr_dq",      32'(s1_dq),   32'(d));
      chk("wr_busy",    32'(bus1.o_busy), 32'd1);
      chk("wr_ack_early", 32'(bus1.o_wr_ack), 32'd0);
      tick;
      chk("wr_ack",     32'(bus1.o_wr_ack), 32'd1);
      chk("wr_done_we", 32'(s1_we_n), 32'd1);
      chk("wr_done_dq_released", 32'(s1_dq), 32'd0);
      bus1.i_wr_req = 1'b0;
      ref_mem[a[11:0]] = d;
      tick;
      chk("wr_ack_pulse", 32'(bus1.o_wr_ack), 32'd0);
      chk("wr_idle_busy", 32'(bus1.o_busy), 32'd0);
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      bus1.i_rd_req = 1'b1; bus1.i_rd_addr = a;
      tick;
      chk("rd_oe_low",  32'(s1_oe_n), 32'd0);
      chk("rd_we_high", 32'(s1_we_n), 32'd1);
      chk("rd_addr",    32'(s1_addr), 32'(a));
      chk("rd_dq_not_driven", 32'(s1_dq), 32'(ref_mem[a[11:0]]));
      tick;
      chk("rd_ack",     32'(bus1.o_rd_ack), 32'd1);
      chk("rd_data",    32'(bus1.o_rd_data), 32'(ref_mem[a[11:0]]));
      chk("rd_done_oe", 32'(s1_oe_n), 32'd1);
      bus1.i_rd_req = 1'b0;
      tick;
      chk("rd_ack_pulse", 32'(bus1.o_rd_ack), 32'd0);
      chk("rd_data_hold", 32'(bus1.o_rd_data), 32'(ref_mem[a[11:0]]));
   endtask

   initial begin
      int unsigned c0, n, k, oe_cnt, last_ack, wr_t0, rd_t0;
      logic wr_p, rd_p;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, held;

      rst_n = 1'b0;
      bus1.i_wr_req = 1'b0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0;
      bus1.i_rd_req = 1'b0; bus1.i_rd_addr = '0;
      bus3.i_wr_req = 1'b0; bus3.i_wr_addr = '0; bus3.i_wr_data = '0;
      bus3.i_rd_req = 1'b0; bus3.i_rd_addr = '0;
      for (int i = 0; i < int'(MEM_N); i++) begin
         mem1[i] = '0;
         ref_mem[i] = '0;
      end

      // Reset values
      tick; tick;
      chk("rst_we",   32'(s1_we_n), 32'd1);
      chk("rst_oe",   32'(s1_oe_n), 32'd1);
      chk("rst_ce",   32'(s1_ce_n), 32'd1);
      chk("rst_lbub", 32'({s1_lb_n, s1_ub_n}), 32'd0);
      chk("rst_addr", 32'(s1_addr), 32'd0);
      chk("rst_dq",   32'(s1_dq), 32'd0);
      chk("rst_busy", 32'(bus1.o_busy), 32'd0);
      chk("rst_acks", 32'({bus1.o_wr_ack, bus1.o_rd_ack}), 32'd0);
      chk("rst_rdata", 32'(bus1.o_rd_data), 32'd0);
      rst_n = 1'b1;
      tick;

      // Directed writes and read-backs
      do_write(20'h00012, 16'hBEEF);
      do_write(20'h0FFFF, 16'hA5A5);
      do_read(20'h0FFFF);
      do_read(20'h00012);

      // Reset in the middle of a read aborts it without an ack
      bus1.i_rd_req = 1'b1; bus1.i_rd_addr = 20'h00012;
      tick;
      chk("rstrd_oe_low", 32'(s1_oe_n), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rstrd_strobes", 32'({s1_we_n, s1_oe_n, s1_ce_n}), 32'd7);
      chk("rstrd_busy", 32'(bus1.o_busy), 32'd0);
      chk("rstrd_ack", 32'(bus1.o_rd_ack), 32'd0);
      bus1.i_rd_req = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick;
         chk("rstrd_no_ack", 32'(bus1.o_rd_ack), 32'd0);
      end

      // Simultaneous held requests: WR first after reset, then strict alternation every 3 cycles
      bus1.i_wr_req = 1'b1; bus1.i_wr_addr = 20'h00001; bus1.i_wr_data = 16'h1111;
      bus1.i_rd_req = 1'b1; bus1.i_rd_addr = 20'h00002;
      c0 = cyc; n = 0;
      for (int t = 0; t < 11; t++) begin
         tick;
         chk("tie_ack_excl", 32'(bus1.o_wr_ack & bus1.o_rd_ack), 32'd0);
         if (bus1.o_wr_ack || bus1.o_rd_ack) begin
            chk("tie_side", 32'(bus1.o_rd_ack), n % 2);
            chk("tie_time", cyc - c0, 2 + 3 * n);
            if (bus1.o_rd_ack) chk("tie_rdata", 32'(bus1.o_rd_data), 32'(ref_mem[2]));
            if (bus1.o_wr_ack) ref_mem[1] = 16'h1111;
            n++;
         end
      end
      bus1.i_wr_req = 1'b0; bus1.i_rd_req = 1'b0;
      chk("tie_count", n, 32'd4);
      tick; tick;

      // Back-to-back reads with ACCESS_CYCLES=3
      bus3.i_rd_req = 1'b1; bus3.i_rd_addr = '0;
      k = 0; oe_cnt = 0; last_ack = 0; held = '0;
      for (int t = 0; t < 40 && k < 4; t++) begin
         tick;
         if (!s3_oe_n) oe_cnt++;
         if (bus3.o_rd_ack) begin
            chk("b2b_data", 32'(bus3.o_rd_data), 32'(pat(bus3.i_rd_addr)));
            chk("b2b_oe_cycles", oe_cnt, 32'd3);
            if (k > 0) chk("b2b_gap", cyc - last_ack, 32'd5);
            last_ack = cyc;
            held = pat(bus3.i_rd_addr);
            oe_cnt = 0;
            k++;
            bus3.i_rd_addr = AW'(k);
            if (k == 4) bus3.i_rd_req = 1'b0;
         end else begin
            chk("b2b_hold", 32'(bus3.o_rd_data), 32'(held));
         end
      end
      chk("b2b_count", k, 32'd4);

      // Random traffic against the reference memory
      wr_p = 1'b0; rd_p = 1'b0; wr_t0 = 0; rd_t0 = 0;
      wa = '0; ra = '0; wd = '0;
      for (int i = 0; i < int'(N_RND); i++) begin
         tick;
         if (!s1_we_n || !s1_oe_n) begin
            chk("rnd_we_oe_excl", 32'(!s1_we_n && !s1_oe_n), 32'd0);
            if (!s1_we_n) begin
               chk("rnd_wr_pending", 32'(wr_p), 32'd1);
               chk("rnd_wr_addr", 32'(s1_addr), 32'(wa));
               chk("rnd_wr_dq", 32'(s1_dq), 32'(wd));
            end
            if (!s1_oe_n) begin
               chk("rnd_rd_pending", 32'(rd_p), 32'd1);
               chk("rnd_rd_addr", 32'(s1_addr), 32'(ra));
               chk("rnd_rd_dq_contention", 32'(s1_dq), 32'(mem1[ra[11:0]]));
            end
         end
         if (bus1.o_wr_ack) begin
            chk("rnd_wr_ack_once", 32'(wr_p), 32'd1);
            chk("rnd_wr_wait", 32'(cyc - wr_t0 <= BOUND), 32'd1);
            ref_mem[wa[11:0]] = wd;
            wr_p = 1'b0;
            bus1.i_wr_req = 1'b0;
         end
         if (bus1.o_rd_ack) begin
            chk("rnd_rd_ack_once", 32'(rd_p), 32'd1);
            chk("rnd_rd_wait", 32'(cyc - rd_t0 <= BOUND), 32'd1);
            chk("rnd_rd_data", 32'(bus1.o_rd_data), 32'(ref_mem[ra[11:0]]));
            rd_p = 1'b0;
            bus1.i_rd_req = 1'b0;
         end
         if (i < int'(N_RND) - 30) begin
            if (!wr_p && $urandom_range(2) == 0) begin
               wa = AW'($urandom_range(255));
               wd = DW'($urandom);
               wr_p = 1'b1; wr_t0 = cyc;
               bus1.i_wr_req = 1'b1; bus1.i_wr_addr = wa; bus1.i_wr_data = wd;
            end
            if (!rd_p && $urandom_range(2) == 0) begin
               ra = AW'($urandom_range(255));
               rd_p = 1'b1; rd_t0 = cyc;
               bus1.i_rd_req = 1'b1; bus1.i_rd_addr = ra;
            end
         end
      end
      chk("rnd_wr_drained", 32'(wr_p), 32'd0);
      chk("rnd_rd_drained", 32'(rd_p), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
